countdown_display: RTL and testbench
====================================

COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (minimum 2).
REQ-002 Parameter BLANK_CYCLES, default 500, ghost-suppression cycles at slot start (less than REFRESH_DIV).
REQ-003 clk  input  1  system clock; one clock domain, all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 value_three  input  4  BCD hundreds digit from countdown.
REQ-006 value_two  input  4  BCD tens digit.
REQ-007 value_one  input  4  BCD ones digit.
REQ-008 sec_timer  input  1  one-cycle pulse, once per second.
REQ-009 an  output  3  digit anodes, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 refresh_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-012 digit_idx SHALL advance 0->1->2->0 on the cycle refresh_cnt wraps.
REQ-013 Frame latch: hundreds, tens and ones SHALL be captured from the inputs on every cycle where digit_idx goes 2->0, and on the first cycle after reset release; input changes at any other time SHALL NOT affect the display until the next latch.
REQ-014 an and seg SHALL be registered: each is a function of the pre-edge refresh_cnt, digit_idx, latched digits and blink_phase, giving 1-cycle latency.
REQ-015 Slot anode SHALL be low only when all four hold: refresh_cnt >= BLANK_CYCLES, the digit is not blanked, blink_phase=0, and it is the selected slot. All other anodes SHALL be high.
REQ-016 Leading-zero blanking: hundreds SHALL be blanked if it is 0; tens SHALL be blanked if hundreds=0 and tens=0; ones SHALL never be blanked.
REQ-017 Decode for the selected digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Codes 10-15 SHALL decode to a dash, 0111111 (g only).
REQ-019 seg SHALL be driven with the selected digit's code even while its anode is high.
REQ-020 blink_phase SHALL be forced to 0 whenever the latched value is not 000, or when the blink feature is compiled out.

Reset
REQ-021 While reset=1 at posedge: an=111, seg=1111111, refresh_cnt=0, digit_idx=0, blink_phase=0, latched digits=9,9,9.
REQ-022 Reset asserted mid-slot or mid-frame SHALL abort the scan on that edge; no partial slot SHALL complete.
REQ-023 On the first cycle after release, the inputs SHALL be latched per REQ-013.

Configuration
REQ-024 Macro COUNTDOWN_DISPLAY_BLINK_EN selects the expiry blink.
REQ-025 With the macro defined: while the latched value is 000, each sec_timer pulse SHALL toggle blink_phase, blinking the "0" at 0.5 Hz. A sec_timer pulse coinciding with a latch of a nonzero value SHALL leave blink_phase=0.
REQ-026 With the macro undefined: sec_timer SHALL be ignored and blink_phase SHALL be constant 0.

Verification
REQ-027 Reset: hold reset 3 cycles with inputs 3,0,0 -> an=111 and seg=1111111 during reset; after release the hundreds slot shows seg=0110000, and the tens and ones slots show 1000000 ("300").
REQ-028 Blanking and ghosting: REFRESH_DIV=4, BLANK_CYCLES=1, inputs 0,0,7 -> an[0]=0 with seg=1111000 for 3 of every 4 ones-slot cycles; an[2:1] stay 11 throughout the frame.
REQ-029 Tearing: change inputs from 1,2,3 to 4,5,6 while digit_idx=1 -> the remainder of the frame still shows 1,2,3; the next frame shows 4,5,6.
REQ-030 Invalid code: value_two=12, value_three=1 -> the tens slot shows seg=0111111.
REQ-031 Blink (macro defined): latched 0,0,0, apply 2 sec_timer pulses -> after pulse 1 an=111 constantly; after pulse 2 an[0] scans again with seg=1000000. With the macro undefined the same stimulus shows no blanking.
REQ-032 Mid-scan reset: assert reset at refresh_cnt=2, digit_idx=2 -> next cycle an=111; after release the scan restarts at digit_idx=0 with refresh_cnt=0.

Source files
------------

// File: rtl/countdown_display.sv
// Multiplexed 3-digit 7-segment driver for a BCD countdown with leading-zero blanking.
// Define COUNTDOWN_DISPLAY_BLINK_EN to blink the display once the latched value reaches 000.
module countdown_display #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    input  logic       sec_timer,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);
    localparam logic [3:0]       RESET_DIGIT = 4'd9;
    localparam logic [6:0]       SEG_OFF     = 7'b1111111;
    localparam logic [2:0]       AN_OFF      = 3'b111;

    typedef enum logic [1:0] {
        SLOT_ONES     = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2
    } slot_e;

    slot_e            digit_idx_q, digit_idx_d;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [3:0]       hundreds_q, hundreds_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             first_q, first_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             blink_phase_q;

    logic             slot_wrap_c;
    logic             frame_latch_c;
    logic             next_zero_c;
    logic [3:0]       sel_digit_c;
    logic             sel_blank_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b0111111;
        endcase
        return code;
    endfunction

    // Scan state register; reset aborts any slot in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_idx_q   <= SLOT_ONES;
            refresh_cnt_q <= '0;
            hundreds_q    <= RESET_DIGIT;
            tens_q        <= RESET_DIGIT;
            ones_q        <= RESET_DIGIT;
            first_q       <= 1'b1;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
        end else begin
            digit_idx_q   <= digit_idx_d;
            refresh_cnt_q <= refresh_cnt_d;
            hundreds_q    <= hundreds_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            first_q       <= first_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    // Refresh counter and slot sequencing
    always_comb begin
        digit_idx_d   = digit_idx_q;
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        slot_wrap_c   = (refresh_cnt_q == CNT_MAX);
        if (slot_wrap_c) begin
            refresh_cnt_d = '0;
            case (digit_idx_q)
                SLOT_ONES:     digit_idx_d = SLOT_TENS;
                SLOT_TENS:     digit_idx_d = SLOT_HUNDREDS;
                SLOT_HUNDREDS: digit_idx_d = SLOT_ONES;
                default:       digit_idx_d = SLOT_ONES;
            endcase
        end
    end

    // Digits are only sampled at frame boundaries so a frame never tears
    always_comb begin
        hundreds_d    = hundreds_q;
        tens_d        = tens_q;
        ones_d        = ones_q;
        first_d       = 1'b0;
        frame_latch_c = first_q || (slot_wrap_c && (digit_idx_q == SLOT_HUNDREDS));
        if (frame_latch_c) begin
            hundreds_d = value_three;
            tens_d     = value_two;
            ones_d     = value_one;
        end
        next_zero_c = (hundreds_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
    end

`ifdef COUNTDOWN_DISPLAY_BLINK_EN
    logic blink_phase_d;

    // Phase only toggles while the value that will be shown is 000
    always_comb begin
        blink_phase_d = 1'b0;
        if (next_zero_c) begin
            blink_phase_d = blink_phase_q ^ sec_timer;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_phase_q <= 1'b0;
        end else begin
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic unused_blink_inputs;

    assign unused_blink_inputs = sec_timer ^ next_zero_c;
    assign blink_phase_q       = 1'b0;
`endif

    // Select the active digit and apply leading-zero blanking
    always_comb begin
        sel_digit_c = ones_q;
        sel_blank_c = 1'b0;
        case (digit_idx_q)
            SLOT_ONES: begin
                sel_digit_c = ones_q;
                sel_blank_c = 1'b0;
            end
            SLOT_TENS: begin
                sel_digit_c = tens_q;
                sel_blank_c = (hundreds_q == 4'd0) && (tens_q == 4'd0);
            end
            SLOT_HUNDREDS: begin
                sel_digit_c = hundreds_q;
                sel_blank_c = (hundreds_q == 4'd0);
            end
            default: begin
                sel_digit_c = ones_q;
                sel_blank_c = 1'b0;
            end
        endcase
    end

    // Anode is held off for the ghost-suppression window at slot start
    always_comb begin
        an_d  = AN_OFF;
        seg_d = seg_decode(sel_digit_c);
        if ((refresh_cnt_q >= BLANK_START) && !sel_blank_c && !blink_phase_q) begin
            case (digit_idx_q)
                SLOT_ONES:     an_d = 3'b110;
                SLOT_TENS:     an_d = 3'b101;
                SLOT_HUNDREDS: an_d = 3'b011;
                default:       an_d = AN_OFF;
            endcase
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard bench for countdown_display; honours COUNTDOWN_DISPLAY_BLINK_EN like the design.
module tb_countdown_display;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
`ifdef COUNTDOWN_DISPLAY_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
    } exp_t;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] value_three, value_two, value_one;
    logic       sec_timer;
    logic [2:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    countdown_display #(
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_three(value_three),
        .value_two  (value_two),
        .value_one  (value_one),
        .sec_timer  (sec_timer),
        .an         (an),
        .seg        (seg)
    );

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    string scen   = "init";

    // Reference model state
    int         m_cnt, m_idx;
    logic [3:0] m_h, m_t, m_o;
    logic       m_blink, m_first;

    // Observation counters for directed checks
    exp_t tgt [3];
    int   hits [3];
    int   any_lit, upper_lit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", scen, tag, got, expv, $time);
        end
    endtask

    task automatic clear_stats(input exp_t t0, input exp_t t1, input exp_t t2);
        tgt[0] = t0; tgt[1] = t1; tgt[2] = t2;
        for (int i = 0; i < 3; i++) hits[i] = 0;
        any_lit   = 0;
        upper_lit = 0;
    endtask

    task automatic step(input logic rst, input logic [3:0] h, input logic [3:0] t,
                        input logic [3:0] o, input logic sec);
        exp_t       e, got;
        logic [3:0] dsel;
        logic       blank;
        reset       = rst;
        value_three = h;
        value_two   = t;
        value_one   = o;
        sec_timer   = sec;
        if (rst) begin
            e.an  = 3'b111;
            e.seg = 7'b1111111;
        end else begin
            case (m_idx)
                0:       begin dsel = m_o; blank = 1'b0; end
                1:       begin dsel = m_t; blank = (m_h == 4'd0) && (m_t == 4'd0); end
                default: begin dsel = m_h; blank = (m_h == 4'd0); end
            endcase
            e.seg = SEG_TBL[dsel];
            e.an  = 3'b111;
            if (m_cnt >= int'(BLANK) && !blank && !m_blink) e.an[m_idx] = 1'b0;
        end
        exp_q.push_back(e);
        if (rst) begin
            m_cnt = 0; m_idx = 0;
            m_h = 4'd9; m_t = 4'd9; m_o = 4'd9;
            m_blink = 1'b0; m_first = 1'b1;
        end else begin
            if (m_first || (m_cnt == int'(DIV) - 1 && m_idx == 2)) begin
                m_h = h; m_t = t; m_o = o;
            end
            m_first = 1'b0;
            if (m_cnt == int'(DIV) - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 3;
            end else begin
                m_cnt++;
            end
            if (BLINK_EN && {m_h, m_t, m_o} == 12'h000) m_blink = m_blink ^ sec;
            else m_blink = 1'b0;
        end
        @(posedge clk);
        #1;
        got.an  = an;
        got.seg = seg;
        e = exp_q.pop_front();
        check("an", 32'(got.an), 32'(e.an));
        check("seg", 32'(got.seg), 32'(e.seg));
        for (int i = 0; i < 3; i++) if (got == tgt[i]) hits[i]++;
        if (an != 3'b111) any_lit++;
        if (an[2:1] != 2'b11) upper_lit++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        for (int i = 0; i < n; i++) step(1'b0, h, t, o, 1'b0);
    endtask

    localparam exp_t NONE = '{an: 3'b111, seg: 7'b1111111};

    initial begin
        int found;
        reset = 1'b1; value_three = 4'd0; value_two = 4'd0; value_one = 4'd0; sec_timer = 1'b0;
        m_cnt = 0; m_idx = 0; m_h = 4'd9; m_t = 4'd9; m_o = 4'd9; m_blink = 1'b0; m_first = 1'b1;
        clear_stats(NONE, NONE, NONE);
        @(negedge clk);

        // Reset holds display dark, then "300"
        scen = "reset";
        for (int i = 0; i < 3; i++) step(1'b1, 4'd3, 4'd0, 4'd0, 1'b0);
        clear_stats('{3'b011, 7'b0110000}, '{3'b101, 7'b1000000}, '{3'b110, 7'b1000000});
        run(24, 4'd3, 4'd0, 4'd0);
        check("hund_3", 32'(hits[0]), 32'd6);
        check("tens_0", 32'(hits[1]), 32'd6);
        check("ones_0", 32'(hits[2]), 32'd6);

        // Leading-zero blanking and ghost window
        scen = "blank";
        step(1'b1, 4'd0, 4'd0, 4'd7, 1'b0);
        clear_stats('{3'b110, 7'b1111000}, NONE, NONE);
        run(36, 4'd0, 4'd0, 4'd7);
        check("ones_7", 32'(hits[0]), 32'd9);
        check("upper_dark", 32'(upper_lit), 32'd0);

        // Mid-frame input change must not tear
        scen = "tear";
        step(1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
        clear_stats('{3'b011, 7'b1111001}, '{3'b101, 7'b0100100}, '{3'b011, 7'b0011001});
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1'b0, 4'd1, 4'd2, 4'd3, 1'b0);
            if (m_idx == 1) found = 1;
        end
        check("tear_reach", 32'(found), 32'd1);
        run(24, 4'd4, 4'd5, 4'd6);
        check("hund_1", 32'(hits[0]), 32'd3);
        check("tens_2", 32'(hits[1]), 32'd3);
        check("hund_4", 32'(hits[2]), 32'd3);

        // Out-of-range BCD shows a dash
        scen = "invalid";
        step(1'b1, 4'd1, 4'd12, 4'd5, 1'b0);
        clear_stats('{3'b101, 7'b0111111}, '{3'b011, 7'b1111001}, NONE);
        run(13, 4'd1, 4'd12, 4'd5);
        check("tens_dash", 32'(hits[0]), 32'd3);
        check("hund_1", 32'(hits[1]), 32'd3);

        // Expiry blink on sec_timer pulses
        scen = "blink";
        step(1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
        run(8, 4'd0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        clear_stats('{3'b110, 7'b1000000}, NONE, NONE);
        run(16, 4'd0, 4'd0, 4'd0);
        check("p1_ones", 32'(hits[0]), BLINK_EN ? 32'd0 : 32'd3);
        check("p1_any", 32'(any_lit), BLINK_EN ? 32'd0 : 32'd3);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        clear_stats('{3'b110, 7'b1000000}, NONE, NONE);
        run(16, 4'd0, 4'd0, 4'd0);
        check("p2_ones", 32'(hits[0]), 32'd5);

        // Pulse coinciding with a nonzero latch leaves blink off
        scen = "blink_latch";
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (m_cnt == int'(DIV) - 1 && m_idx == 2) found = 1;
            else step(1'b0, 4'd0, 4'd0, 4'd8, 1'b0);
        end
        check("latch_reach", 32'(found), 32'd1);
        step(1'b0, 4'd0, 4'd0, 4'd8, 1'b1);
        clear_stats('{3'b110, 7'b0000000}, NONE, NONE);
        run(12, 4'd0, 4'd0, 4'd8);
        check("ones_8", 32'(hits[0]), 32'd3);

        // Reset mid-slot restarts the scan at the ones slot
        scen = "midreset";
        step(1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (m_cnt == 2 && m_idx == 2) found = 1;
            else step(1'b0, 4'd1, 4'd2, 4'd3, 1'b0);
        end
        check("mid_reach", 32'(found), 32'd1);
        clear_stats('{3'b110, 7'b0110000}, NONE, NONE);
        step(1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
        check("mid_dark", 32'(any_lit), 32'd0);
        run(4, 4'd1, 4'd2, 4'd3);
        check("ones_3", 32'(hits[0]), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
